// File: rtl/pong_game_ctrl.sv
// Game-level controller for the two-player pong display path.
// Owns the NEWGAME/PLAY/NEWBALL/OVER state machine, both scores, the winner flag
// and the shared serve / game-over delay timer. Every output is decoded from
// registers, so no input reaches an output combinationally.
module pong_game_ctrl #(
    parameter int unsigned DELAY_CYCLES = 200_000_000,  // pause length in clk cycles, >= 2
    parameter int unsigned TIMER_W      = 28,           // 2**TIMER_W > DELAY_CYCLES
    parameter int unsigned WIN_SCORE    = 9             // 1..9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       pts_1,
    input  logic       pts_2,
    output logic       gra_still,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic       winner,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_e;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DELAY_CYCLES - 1);
    localparam logic [3:0]         WIN        = 4'(WIN_SCORE);

    state_e               state_q, state_d;
    logic [3:0]           score1_q, score1_d;
    logic [3:0]           score2_q, score2_d;
    logic                 winner_q, winner_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 btn_any_q;

    logic                 btn_any;
    logic                 press;
    logic [3:0]           score1_inc;
    logic [3:0]           score2_inc;
    logic                 timer_done;

    // A start press is the rising edge of "any button"; the history bit resets
    // high so a button held through reset never counts as a press.
    assign btn_any    = |btn;
    assign press      = btn_any & ~btn_any_q;
    assign score1_inc = score1_q + 4'd1;
    assign score2_inc = score2_q + 4'd1;
    assign timer_done = (timer_q == TIMER_LAST);

    // Register the state, scores, winner, timer and button history.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= ST_NEWGAME;
            score1_q  <= 4'd0;
            score2_q  <= 4'd0;
            winner_q  <= 1'b0;
            timer_q   <= '0;
            btn_any_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            score1_q  <= score1_d;
            score2_q  <= score2_d;
            winner_q  <= winner_d;
            timer_q   <= timer_d;
            btn_any_q <= btn_any;
        end
    end

    // Next-state logic: start on press, score points in PLAY, run the pause timer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned, which would infer a latch.
        state_d  = state_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        timer_d  = '0;  // the timer is held at zero outside the pause states

        unique case (state_q)
            ST_NEWGAME: begin
                if (press) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Player 1 takes priority when both strobes arrive together.
                if (pts_1) begin
                    score1_d = score1_inc;
                    if (score1_inc == WIN) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d = ST_NEWBALL;
                    end
                end else if (pts_2) begin
                    score2_d = score2_inc;
                    if (score2_inc == WIN) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d = ST_NEWBALL;
                    end
                end
            end
            ST_NEWBALL: begin
                if (timer_done) begin
                    state_d = ST_PLAY;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_OVER: begin
                if (timer_done) begin
                    state_d  = ST_NEWGAME;
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    winner_d = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_NEWGAME;
            end
        endcase
    end

    assign state     = state_q;
    assign gra_still = (state_q != ST_PLAY);
    assign game_over = (state_q == ST_OVER);
    assign winner    = winner_q;
    assign score1    = score1_q;
    assign score2    = score2_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: a table of directed multi-cycle
// scenarios followed by randomized play compared against a countdown-based
// reference model of the game rules.
module tb_pong_game_ctrl;

    localparam int D   = 10;
    localparam int WIN = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       pts_1, pts_2;
    logic       gra_still;
    logic [3:0] score1, score2;
    logic       game_over, winner;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    pong_game_ctrl #(
        .DELAY_CYCLES(D),
        .TIMER_W     (8),
        .WIN_SCORE   (WIN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .pts_1    (pts_1),
        .pts_2    (pts_2),
        .gra_still(gra_still),
        .score1   (score1),
        .score2   (score2),
        .game_over(game_over),
        .winner   (winner),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Reference model: phase number, scores, winner and the number of pause
    // cycles still to run before the pause state is left.
    int m_phase, m_s1, m_s2, m_win, m_left, m_prev;

    function automatic void model_step(input bit r, input logic [3:0] b, input bit p1, input bit p2);
        bit pressed;
        if (r) begin
            m_phase = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_left = 0; m_prev = 1;
            return;
        end
        pressed = (b != 0) && (m_prev == 0);
        m_prev  = (b != 0) ? 1 : 0;
        case (m_phase)
            0: if (pressed) m_phase = 1;
            1: begin
                if (p1) begin
                    m_s1++;
                    m_left = D;
                    if (m_s1 == WIN) begin m_phase = 3; m_win = 0; end
                    else m_phase = 2;
                end else if (p2) begin
                    m_s2++;
                    m_left = D;
                    if (m_s2 == WIN) begin m_phase = 3; m_win = 1; end
                    else m_phase = 2;
                end
            end
            2: begin
                m_left--;
                if (m_left == 0) m_phase = 1;
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
                end
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, step the model, settle.
    task automatic cycle(input bit r, input logic [3:0] b, input bit p1, input bit p2);
        reset = r; btn = b; pts_1 = p1; pts_2 = p2;
        @(posedge clk);
        model_step(r, b, p1, p2);
        #1;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] btn;
        bit         p1;
        bit         p2;
        int         n;
        logic [1:0] st;
        logic [3:0] s1;
        logic [3:0] s2;
        bit         go;
        bit         w;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit r, input logic [3:0] b, input bit p1, input bit p2,
                                input int n, input logic [1:0] st, input logic [3:0] s1,
                                input logic [3:0] s2, input bit go, input bit w);
        vec_t v;
        v.rst = r; v.btn = b; v.p1 = p1; v.p2 = p2; v.n = n;
        v.st = st; v.s1 = s1; v.s2 = s2; v.go = go; v.w = w;
        vecs.push_back(v);
    endfunction

    initial begin
        reset = 1'b1; btn = 4'd0; pts_1 = 1'b0; pts_2 = 1'b0;
        m_phase = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_left = 0; m_prev = 1;

        //  rst btn  p1 p2  n   st    s1 s2 go w
        // Reset and hold idle.
        add(1, 4'h0, 0, 0, 2,  2'b00, 0, 0, 0, 0);
        add(0, 4'h0, 0, 0, 20, 2'b00, 0, 0, 0, 0);
        // Start, one point for player 1 held three cycles, serve pause.
        add(0, 4'h1, 0, 0, 1,  2'b01, 0, 0, 0, 0);
        add(0, 4'h0, 1, 0, 1,  2'b10, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 2,  2'b10, 1, 0, 0, 0);
        add(0, 4'h0, 0, 0, 7,  2'b10, 1, 0, 0, 0);
        add(0, 4'h0, 0, 0, 1,  2'b01, 1, 0, 0, 0);
        // Player 2 wins with three points.
        add(0, 4'h0, 0, 1, 1,  2'b10, 1, 1, 0, 0);
        add(0, 4'h0, 0, 0, 9,  2'b10, 1, 1, 0, 0);
        add(0, 4'h0, 0, 0, 1,  2'b01, 1, 1, 0, 0);
        add(0, 4'h0, 0, 1, 1,  2'b10, 1, 2, 0, 0);
        add(0, 4'h0, 0, 0, 9,  2'b10, 1, 2, 0, 0);
        add(0, 4'h0, 0, 0, 1,  2'b01, 1, 2, 0, 0);
        add(0, 4'h0, 0, 1, 1,  2'b11, 1, 3, 1, 1);
        add(0, 4'h0, 0, 1, 5,  2'b11, 1, 3, 1, 1);
        // Button held from OVER into NEWGAME must not start a game.
        add(0, 4'h4, 0, 0, 4,  2'b11, 1, 3, 1, 1);
        add(0, 4'h4, 0, 0, 1,  2'b00, 0, 0, 0, 0);
        add(0, 4'h4, 0, 0, 5,  2'b00, 0, 0, 0, 0);
        add(0, 4'h0, 0, 0, 2,  2'b00, 0, 0, 0, 0);
        add(0, 4'h4, 0, 0, 1,  2'b01, 0, 0, 0, 0);
        // Simultaneous points count player 1 only; points in NEWBALL ignored.
        add(0, 4'h0, 1, 1, 1,  2'b10, 1, 0, 0, 0);
        add(0, 4'h0, 1, 1, 3,  2'b10, 1, 0, 0, 0);
        add(0, 4'h0, 0, 1, 6,  2'b10, 1, 0, 0, 0);
        add(0, 4'h0, 0, 0, 1,  2'b01, 1, 0, 0, 0);
        // Reset at the 5th cycle of NEWBALL with score1 = 2.
        add(0, 4'h0, 1, 0, 1,  2'b10, 2, 0, 0, 0);
        add(0, 4'h0, 0, 0, 3,  2'b10, 2, 0, 0, 0);
        add(1, 4'h0, 0, 0, 1,  2'b00, 0, 0, 0, 0);
        add(0, 4'h0, 0, 0, 2,  2'b00, 0, 0, 0, 0);
        // The next pause must again last exactly D cycles (timer was cleared).
        add(0, 4'h1, 0, 0, 1,  2'b01, 0, 0, 0, 0);
        add(0, 4'h0, 0, 1, 1,  2'b10, 0, 1, 0, 0);
        add(0, 4'h0, 0, 0, 9,  2'b10, 0, 1, 0, 0);
        add(0, 4'h0, 0, 0, 1,  2'b01, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                cycle(vecs[i].rst, vecs[i].btn, vecs[i].p1, vecs[i].p2);
                check($sformatf("vec%0d.%0d state", i, k), 32'(state), 32'(vecs[i].st));
                check($sformatf("vec%0d.%0d still", i, k), 32'(gra_still), 32'(vecs[i].st != 2'b01));
                check($sformatf("vec%0d.%0d score1", i, k), 32'(score1), 32'(vecs[i].s1));
                check($sformatf("vec%0d.%0d score2", i, k), 32'(score2), 32'(vecs[i].s2));
                check($sformatf("vec%0d.%0d game_over", i, k), 32'(game_over), 32'(vecs[i].go));
                check($sformatf("vec%0d.%0d winner", i, k), 32'(winner), 32'(vecs[i].w));
            end
        end

        // Randomized play against the reference model.
        cycle(1'b1, 4'h0, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            bit         r;
            logic [3:0] b;
            bit         p1, p2;
            logic [12:0] exp_v, act_v;
            r  = ($urandom_range(0, 299) == 0);
            b  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            p1 = ($urandom_range(0, 7) == 0);
            p2 = ($urandom_range(0, 7) == 0);
            cycle(r, b, p1, p2);
            exp_v = {2'(m_phase), 4'(m_s1), 4'(m_s2), (m_phase == 3), 1'(m_win), (m_phase != 1)};
            act_v = {state, score1, score2, game_over, winner, gra_still};
            check($sformatf("rand%0d {state,s1,s2,go,win,still}", c), 32'(act_v), 32'(exp_v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-level controller for the two-player pong display path. It consumes the per-cycle point strobes `pts_1`/`pts_2` from the graphics stage and owns the game state machine. It produces the `gra_still` freeze signal that feeds back into the graphics stage, plus the per-player scores and game-over/winner status for the score/text overlay. It also runs the serve and game-over delay timers and gates game start on a fresh button press.

## Interface
- `DELAY_CYCLES`, 200_000_000 — serve / game-over pause length in clk cycles (2 s at 100 MHz); must be ≥ 2.
- `TIMER_W`, 28 — delay counter width; 2^TIMER_W must be > DELAY_CYCLES.
- `WIN_SCORE`, 9 — score that ends the game; legal range 1..9 (single decimal digit).

- `clk` input 1 — system clock, the same clock as the graphics stage.
- `reset` input 1 — synchronous, active-high reset.
- `btn` input 4 — raw player buttons, same bit map as the graphics stage. Any bit counts as "press".
- `pts_1` input 1 — player 1 scored (ball left the right edge); level, may stay high for many cycles.
- `pts_2` input 1 — player 2 scored (ball left the left edge); level, may stay high for many cycles.
- `gra_still` output 1 — freeze/recenter ball; high in every state except PLAY.
- `score1` output 4 — player 1 score, binary 0..WIN_SCORE.
- `score2` output 4 — player 2 score, binary 0..WIN_SCORE.
- `game_over` output 1 — high in OVER only.
- `winner` output 1 — 0 = player 1 won, 1 = player 2 won; valid while `game_over`=1.
- `state` output 2 — 00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER; used by the overlay to select text.

## Operation
- States are NEWGAME, PLAY, NEWBALL and OVER. All outputs are Moore outputs decoded from registers; there is no combinational input→output path.
- `press` is the rising edge of `|btn`: `|btn`=1 this cycle and the registered `|btn` from the previous cycle = 0. The registered `|btn` resets to 1, so a button held through reset does not count as a press.
- **NEWGAME**
  - `score1`=`score2`=0.
  - On `press` → PLAY.
- **PLAY**
  - `pts_1`=1 → `score1`+1. If the new value = WIN_SCORE → OVER with `winner`=0; else → NEWBALL.
  - Else `pts_2`=1 → the same for `score2`, with `winner`=1.
  - Simultaneous `pts_1` and `pts_2`: only `pts_1` is counted.
- **NEWBALL**
  - The timer is cleared on entry and increments every cycle.
  - When the timer = DELAY_CYCLES−1 → PLAY.
  - `pts_*` and `btn` are ignored.
- **OVER**
  - The timer runs the same way as in NEWBALL.
  - When the timer = DELAY_CYCLES−1 → NEWGAME, clearing both scores and `winner` on the same edge.
  - `pts_*` and `btn` are ignored.
- The timer counts only in NEWBALL and OVER and is held at 0 in all other states.
- Scores saturate structurally: the increment happens only in PLAY, and the game leaves PLAY as soon as a score reaches WIN_SCORE, so a score never exceeds WIN_SCORE.

## Timing
- Reset values, taking effect on the first clk edge with `reset`=1: `state`=NEWGAME, `gra_still`=1, `score1`=`score2`=0, `game_over`=0, `winner`=0, timer=0.
- `reset` overrides every transition, including mid-delay and mid-point.
- Point latency: `pts_x` sampled high at edge N gives the following at edge N:
  - the score updates;
  - `state` leaves PLAY;
  - `gra_still` goes high.
- The graphics stage recenters the ball one edge later. `pts_x` stays asserted during that window, but it is ignored because the state is no longer PLAY. Exactly one point is counted per ball exit.
- NEWBALL and OVER last exactly DELAY_CYCLES cycles, from the entering edge to the edge that leaves the state.
- Start latency: a `press` sampled at edge N gives `state`=PLAY and `gra_still`=0 from edge N.
- A button held continuously from OVER into NEWGAME does not start a game; the player must release and press again.

## Test plan
Bench parameters for all scenarios: DELAY_CYCLES=10, WIN_SCORE=3.

1. **Reset and hold:** assert `reset` for 2 cycles, then hold `btn`=0 for 20 cycles → `state`=00, `gra_still`=1, both scores 0 throughout.
2. **Start, point, serve:**
   - Stimulus: pulse `btn[0]` for 1 cycle, then `pts_1`=1 for 3 cycles.
   - Required: `state`=01 and `gra_still`=0 one edge after the press.
   - Required: exactly one increment of `score1` (to 1), then `state`=10 for exactly 10 cycles, then back to 01.
3. **Win, player 2:**
   - Stimulus: three `pts_2` events, each separated by the serve delay.
   - Required: `score2`=3, `state`=11, `game_over`=1, `winner`=1.
   - Required: after 10 cycles `state`=00 with scores and `winner` cleared.
4. **Held button:** keep `btn[2]`=1 from OVER through entry into NEWGAME → `state` stays 00. Release and press again → `state`=01.
5. **Simultaneous points:** `pts_1`=`pts_2`=1 in PLAY → `score1`+1 and `score2` unchanged. Any `pts_*` asserted during NEWBALL leaves both scores unchanged.
6. **Reset mid-operation:** assert `reset` at the 5th cycle of NEWBALL with `score1`=2 → on the next edge `state`=00, scores 0, timer 0, `gra_still`=1.
